// File: rtl/sipo_deser_pkg.sv
// Shared constants and output-state encoding for the serial-to-parallel deserializer.
package sipo_deser_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int CNT_W         = $clog2(DEFAULT_WIDTH);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_t;

endpackage

// File: rtl/sipo_deser_if.sv
// Serial input strobe, frame control and parallel output handshake of the deserializer.
interface sipo_deser_if
    import sipo_deser_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic                     serial_in;
    logic                     shift_en;
    logic                     msb_first;
    logic                     clear;
    logic                     out_ready;
    logic [WIDTH-1:0]         parallel_out;
    logic                     out_valid;
    logic [$clog2(WIDTH)-1:0] bit_cnt;
    logic                     overrun;

    modport master (
        output serial_in, shift_en, msb_first, clear, out_ready,
        input  parallel_out, out_valid, bit_cnt, overrun
    );

    modport slave (
        input  serial_in, shift_en, msb_first, clear, out_ready,
        output parallel_out, out_valid, bit_cnt, overrun
    );

endinterface

// File: rtl/sipo_bit_counter.sv
// Modulo-WIDTH bit position counter; tc flags the bit that completes a word.
module sipo_bit_counter
    import sipo_deser_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     clr,
    output logic [$clog2(WIDTH)-1:0] cnt,
    output logic                     tc
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    assign tc = en && (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tc ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sipo_deser.sv
// Serial-in parallel-out deserializer with per-frame bit order and a one-word output buffer.
module sipo_deser
    import sipo_deser_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    sipo_deser_if.slave  bus
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] next_sr;
    logic [WIDTH-1:0] word_q;
    logic [CW-1:0]    cnt;
    logic             mode_q;
    logic             mode;
    logic             advance;
    logic             complete;
    logic             overrun_q;
    out_state_t       state;

    assign advance = bus.shift_en & ~bus.clear;

    sipo_bit_counter #(.WIDTH(WIDTH)) u_bit_counter (
        .clk (clk),
        .rst (rst),
        .en  (advance),
        .clr (bus.clear),
        .cnt (cnt),
        .tc  (complete)
    );

    // The first bit of a frame must already obey the msb_first value being latched.
    assign mode    = (cnt == '0) ? bus.msb_first : mode_q;
    assign next_sr = mode ? {sr[WIDTH-2:0], bus.serial_in}
                          : {bus.serial_in, sr[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr     <= '0;
            mode_q <= 1'b1;
        end else if (bus.clear) begin
            sr <= '0;
        end else if (advance) begin
            sr <= next_sr;
            if (cnt == '0) begin
                mode_q <= bus.msb_first;
            end
        end
    end

    // A completed word arriving while the buffer is held is dropped and flagged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            word_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (bus.clear) begin
                overrun_q <= 1'b0;
            end
            case (state)
                EMPTY: begin
                    if (complete) begin
                        word_q <= next_sr;
                        state  <= FULL;
                    end
                end
                FULL: begin
                    if (complete) begin
                        if (bus.out_ready) begin
                            word_q <= next_sr;
                        end else begin
                            overrun_q <= 1'b1;
                        end
                    end else if (bus.out_ready) begin
                        state <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    assign bus.parallel_out = word_q;
    assign bus.out_valid    = (state == FULL);
    assign bus.bit_cnt      = cnt;
    assign bus.overrun      = overrun_q;

endmodule

// File: doc/sipo_deser.md
SIPO_DESER -- requirements
Module: sipo_deser

Interface
REQ-001 Parameter WIDTH, default 8, word length in bits; SHALL be >= 2.
REQ-002 Port clk  input  1  rising-edge clock; the only clock.
REQ-003 Port rst  input  1  reset, asynchronous, active-high.
REQ-004 Port serial_in  input  1  serial data bit, sampled when shift_en=1.
REQ-005 Port shift_en  input  1  bit strobe; one bit is consumed per clk with shift_en=1.
REQ-006 Port msb_first  input  1  1 = first bit lands in MSB, 0 = first bit lands in bit 0; latched at frame start.
REQ-007 Port clear  input  1  synchronous flush of the partial frame and the overrun flag.
REQ-008 Port out_ready  input  1  consumer accepts parallel_out when out_valid=1.
REQ-009 Port parallel_out  output  WIDTH  completed word, registered.
REQ-010 Port out_valid  output  1  parallel_out holds an unconsumed word.
REQ-011 Port bit_cnt  output  $clog2(WIDTH)  bits collected in the current frame.
REQ-012 Port overrun  output  1  sticky; a completed word was dropped.

Function
REQ-013 Shift register sr and counter bit_cnt SHALL advance only on a clk edge with shift_en=1 and clear=0.
REQ-014 On the first bit of a frame (bit_cnt=0), msb_first SHALL be latched into mode_q; mode_q SHALL govern every shift of that frame, including the first.
REQ-015 MSB-first shift: sr <= {sr[WIDTH-2:0], serial_in}. LSB-first shift: sr <= {serial_in, sr[WIDTH-1:1]}.
REQ-016 bit_cnt SHALL count 0..WIDTH-1 and wrap to 0 on the WIDTH-th bit, with no idle gap; back-to-back frames SHALL be accepted.
REQ-017 On the WIDTH-th bit, the completed word (sr with the new bit applied) SHALL load into parallel_out and out_valid SHALL be 1 in the next cycle; latency is 1 clk from the last bit.
REQ-018 Output state machine: EMPTY (out_valid=0) and FULL (out_valid=1). EMPTY->FULL on word completion. FULL->EMPTY on out_ready=1 with no completion. FULL->FULL with a new word on completion and out_ready=1 in the same cycle.
REQ-019 Completion while FULL and out_ready=0: the new word SHALL be dropped, parallel_out SHALL be unchanged, and overrun SHALL be set to 1 and held.
REQ-020 parallel_out SHALL be stable whenever out_valid=1 and out_ready=0.
REQ-021 clear=1 SHALL zero sr and bit_cnt and SHALL clear overrun; it SHALL NOT affect out_valid or parallel_out; clear SHALL take priority over shift_en in the same cycle.
REQ-022 shift_en=0 SHALL hold sr, bit_cnt and mode_q; out_ready handling SHALL continue.

Reset
REQ-023 rst=1 SHALL immediately force: sr=0, bit_cnt=0, mode_q=1, parallel_out=0, out_valid=0, overrun=0.
REQ-024 Reset mid-frame SHALL discard the partial frame; the first shift_en after deassertion SHALL be bit 0 of a new frame.

Structure
REQ-025 Package sipo_deser_pkg SHALL hold the default WIDTH, CNT_W=$clog2(WIDTH), and the EMPTY/FULL state encoding.
REQ-026 One sub-module, sipo_bit_counter (WIDTH-modulo counter with enable, clear, and a terminal-count output), SHALL be instantiated; all other logic stays in sipo_deser.

Verification (WIDTH=8)
REQ-027 Reset then MSB-first bits 1,0,1,1,0,1,0,0 with out_ready=1 -> parallel_out=0xB4, out_valid=1 for exactly one cycle after the 8th bit.
REQ-028 Same bits with msb_first=0 -> parallel_out=0x2D; toggling msb_first mid-frame -> still 0x2D.
REQ-029 Two back-to-back frames 0xB4 then 0x5A, out_ready=0 throughout -> parallel_out stays 0xB4, out_valid=1, overrun=1 after the 16th bit.
REQ-030 out_ready=1 in the same cycle as the 16th bit of back-to-back frames -> out_valid stays 1, parallel_out changes 0xB4->0x5A, overrun=0.
REQ-031 rst asserted after 5 bits, then 8 bits of 0xFF -> parallel_out=0xFF; no mix with the pre-reset bits.
REQ-032 clear pulse after 3 bits, then 8 bits of 0x81 -> parallel_out=0x81, overrun=0, bit_cnt=0 at the cycle after clear.
